vec_wb_stage: RTL

VEC_WB_STAGE -- requirements
Module: vec_wb_stage

---
 rtl/vec_wb_stage.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vec_wb_stage.sv
// Vector writeback stage: in-order destination tag FIFO feeding a result FIFO that drains into the VRF.
// Optional macro VEC_WB_BYPASS_EN presents a completing result combinationally when the result FIFO is empty.
module vec_wb_stage #(
  parameter int unsigned VLEN  = 256,
  parameter int unsigned DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      new_instr,
  input  logic [4:0]                instr_vd,
  input  logic [2:0]                instr_vsew,
  input  logic [$clog2(VLEN/8):0]   instr_vl,
  input  logic                      vec_op_done,
  input  logic [VLEN-1:0]           vec_exec_out,
  output logic                      vrf_we,
  output logic [4:0]                vrf_waddr,
  output logic [VLEN-1:0]           vrf_wdata,
  output logic [VLEN/8-1:0]         vrf_wstrb,
  input  logic                      vrf_ready,
  output logic                      wb_stall,
  output logic                      wb_err
);

  localparam int unsigned NB  = VLEN / 8;
  localparam int unsigned VLW = $clog2(NB) + 1;
  localparam int unsigned PW  = $clog2(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;

  localparam cnt_t FULL_C = cnt_t'(DEPTH);

  // Tag FIFO storage
  logic [4:0]     tag_vd_q  [DEPTH];
  logic [2:0]     tag_sew_q [DEPTH];
  logic [VLW-1:0] tag_vl_q  [DEPTH];
  ptr_t           tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  cnt_t           tag_cnt_q, tag_cnt_d;

  // Result FIFO storage
  logic [4:0]      res_addr_q [DEPTH];
  logic [VLEN-1:0] res_data_q [DEPTH];
  logic [NB-1:0]   res_strb_q [DEPTH];
  ptr_t            res_wr_q, res_wr_d, res_rd_q, res_rd_d;
  cnt_t            res_cnt_q, res_cnt_d;

  logic          tag_full, tag_empty, res_full, res_empty;
  logic          fifo_xfer, op_ok, byp_hit;
  logic          tag_push, tag_pop, res_push, res_pop;
  logic [4:0]    head_vd;
  logic [NB-1:0] head_strb;

  // Byte count is vl scaled by element size; reserved widths (vsew[2]) write nothing.
  function automatic logic [NB-1:0] calc_strb(input logic [2:0] sew, input logic [VLW-1:0] vl);
    logic [VLW+2:0] nb;
    logic [31:0]    nbytes;
    logic [NB-1:0]  s;
    nb     = {3'b000, vl} << sew[1:0];
    nbytes = 32'(nb);
    s      = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      s[i] = (i < nbytes);
    end
    if (sew[2]) begin
      s = '0;
    end
    return s;
  endfunction

  always_comb begin
    tag_full  = (tag_cnt_q == FULL_C);
    tag_empty = (tag_cnt_q == '0);
    res_full  = (res_cnt_q == FULL_C);
    res_empty = (res_cnt_q == '0);

    head_vd   = tag_vd_q[tag_rd_q];
    head_strb = calc_strb(tag_sew_q[tag_rd_q], tag_vl_q[tag_rd_q]);

    fifo_xfer = !res_empty && vrf_ready;
    op_ok     = vec_op_done && !tag_empty && (!res_full || fifo_xfer);

`ifdef VEC_WB_BYPASS_EN
    byp_hit   = op_ok && res_empty && vrf_ready;
`else
    byp_hit   = 1'b0;
`endif

    tag_pop   = op_ok;
    tag_push  = new_instr && (!tag_full || tag_pop);
    res_pop   = fifo_xfer;
    res_push  = op_ok && !byp_hit;

    tag_wr_d  = tag_push ? tag_wr_q + ptr_t'(1) : tag_wr_q;
    tag_rd_d  = tag_pop  ? tag_rd_q + ptr_t'(1) : tag_rd_q;
    res_wr_d  = res_push ? res_wr_q + ptr_t'(1) : res_wr_q;
    res_rd_d  = res_pop  ? res_rd_q + ptr_t'(1) : res_rd_q;

    tag_cnt_d = tag_cnt_q;
    if (tag_push && !tag_pop) begin
      tag_cnt_d = tag_cnt_q + cnt_t'(1);
    end else if (!tag_push && tag_pop) begin
      tag_cnt_d = tag_cnt_q - cnt_t'(1);
    end

    res_cnt_d = res_cnt_q;
    if (res_push && !res_pop) begin
      res_cnt_d = res_cnt_q + cnt_t'(1);
    end else if (!res_push && res_pop) begin
      res_cnt_d = res_cnt_q - cnt_t'(1);
    end
  end

  always_comb begin
    vrf_we    = !res_empty;
    vrf_waddr = res_empty ? '0 : res_addr_q[res_rd_q];
    vrf_wdata = res_empty ? '0 : res_data_q[res_rd_q];
    vrf_wstrb = res_empty ? '0 : res_strb_q[res_rd_q];
`ifdef VEC_WB_BYPASS_EN
    if (res_empty && op_ok) begin
      vrf_we    = 1'b1;
      vrf_waddr = head_vd;
      vrf_wdata = vec_exec_out;
      vrf_wstrb = head_strb;
    end
`endif
    wb_stall = tag_full || res_full;
    wb_err   = reset && ((new_instr && tag_full && !tag_pop) ||
                         (vec_op_done && !op_ok) ||
                         (new_instr && instr_vsew[2]));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
      res_wr_q  <= '0;
      res_rd_q  <= '0;
      res_cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_vd_q[i]   <= '0;
        tag_sew_q[i]  <= '0;
        tag_vl_q[i]   <= '0;
        res_addr_q[i] <= '0;
        res_data_q[i] <= '0;
        res_strb_q[i] <= '0;
      end
    end else begin
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
      tag_cnt_q <= tag_cnt_d;
      res_wr_q  <= res_wr_d;
      res_rd_q  <= res_rd_d;
      res_cnt_q <= res_cnt_d;
      if (tag_push) begin
        tag_vd_q[tag_wr_q]  <= instr_vd;
        tag_sew_q[tag_wr_q] <= instr_vsew;
        tag_vl_q[tag_wr_q]  <= instr_vl;
      end
      if (res_push) begin
        res_addr_q[res_wr_q] <= head_vd;
        res_data_q[res_wr_q] <= vec_exec_out;
        res_strb_q[res_wr_q] <= head_strb;
      end
    end
  end

endmodule
